// File: rtl/vlu_load_sequencer.sv
// ---------------------------------------------------------------------------
// vlu_load_sequencer
//
// Purpose:
//   Turns one vector-load instruction (base byte address, byte length vlB,
//   instruction id) into a stream of BeatBytes-sized memory read requests.
//   It limits the number of beats that have been issued to memory but not yet
//   consumed by the VLU to MaxOutstanding, so the VLU operand buffers never
//   overflow. It pulses done_o once every beat has been consumed.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   req_valid_i      load request valid (from vinsn_launcher)
//   req_ready_o      request accepted; high only while idle
//   req_base_i       base byte address of the load
//   req_vlb_i        total number of bytes to load
//   req_id_i         instruction id
//   mem_req_valid_o  memory read beat request valid
//   mem_req_ready_i  memory accepts the beat
//   mem_req_addr_o   byte address of the current beat (beat aligned)
//   rsp_fire_i       VLU consumed one load operand
//   busy_o           an instruction is in progress
//   done_o           one-cycle completion pulse
//   done_id_o        id of the completed instruction (0 when done_o is low)
// ---------------------------------------------------------------------------
module vlu_load_sequencer #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned BeatBytes      = 16,
  parameter int unsigned VlBWidth       = 16,
  parameter int unsigned IdWidth        = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_base_i,
  input  logic [VlBWidth-1:0]  req_vlb_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [AddrWidth-1:0] mem_req_addr_o,
  input  logic                 rsp_fire_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IdWidth-1:0]   done_id_o
);

  localparam int unsigned OffW = $clog2(BeatBytes);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0]      MaxOut    = OutW'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] AddrStep  = AddrWidth'(BeatBytes);
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(BeatBytes - 1);

  // S_ZERO is the single-cycle completion path for a zero-length load.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_ZERO  = 2'd3
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [VlBWidth-1:0]  r_nbeats;
  logic [VlBWidth-1:0]  r_issued;
  logic [OutW-1:0]      r_out;
  logic [AddrWidth-1:0] r_addr;
  logic [IdWidth-1:0]   r_id;

  logic                 w_accept;
  logic                 w_mem_valid;
  logic                 w_beat;
  logic                 w_rsp;
  logic                 w_last_beat;
  logic                 w_drain_done;
  logic [VlBWidth-1:0]  w_nbeats_req;

  // ceil(vlB / BeatBytes): whole beats plus one if any remainder bytes.
  assign w_nbeats_req = (req_vlb_i >> OffW) + VlBWidth'(|req_vlb_i[OffW-1:0]);

  assign w_accept    = req_valid_i && (r_state == S_IDLE);

  // Valid depends only on registered state, so it cannot glitch with
  // rsp_fire_i and, once high, can only stay high: outstanding never grows
  // without an accepted beat.
  assign w_mem_valid = (r_state == S_ISSUE) && (r_out < MaxOut);
  assign w_beat      = w_mem_valid && mem_req_ready_i;

  // A consume with nothing outstanding is spurious and dropped, which keeps
  // the counter from underflowing.
  assign w_rsp       = rsp_fire_i && (r_out != '0);

  assign w_last_beat = w_beat && ((r_issued + VlBWidth'(1)) == r_nbeats);

  // Completes in the cycle the final consume arrives, not a cycle later.
  assign w_drain_done = (r_state == S_DRAIN) &&
                        ((r_out == '0) || ((r_out == OutW'(1)) && w_rsp));

  // -------------------------------------------------------------------------
  // FSM next state / outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_state_next = (w_nbeats_req == '0) ? S_ZERO : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_last_beat) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          done_o       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_ZERO: begin
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign done_id_o       = done_o ? r_id : '0;
  assign busy_o          = (r_state != S_IDLE);
  assign mem_req_valid_o = w_mem_valid;
  assign mem_req_addr_o  = r_addr;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Instruction context: id, beat count, issue count, beat address
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id     <= '0;
      r_nbeats <= '0;
      r_issued <= '0;
      r_addr   <= '0;
    end else if (w_accept) begin
      r_id     <= req_id_i;
      r_nbeats <= w_nbeats_req;
      r_issued <= '0;
      r_addr   <= req_base_i & AlignMask;
    end else if (w_beat) begin
      r_issued <= r_issued + VlBWidth'(1);
      // Natural AddrWidth overflow gives the modulo-2^AddrWidth wrap.
      r_addr   <= r_addr + AddrStep;
    end
  end

  // -------------------------------------------------------------------------
  // Outstanding (issued but not yet consumed) beat counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out <= '0;
    end else if (w_beat && !w_rsp) begin
      r_out <= r_out + OutW'(1);
    end else if (!w_beat && w_rsp) begin
      r_out <= r_out - OutW'(1);
    end
  end

endmodule

// File: tb/tb_vlu_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vlu_load_sequencer
//
// Purpose:
//   Self-checking bench for vlu_load_sequencer. Stimulus pushes the expected
//   beat addresses and instruction records into scoreboard queues; a monitor
//   on the falling clock edge pops and compares whenever the DUT issues a beat
//   or signals completion. A small memory/VLU model drives mem_req_ready_i and
//   rsp_fire_i with configurable random rates.
// ---------------------------------------------------------------------------
module tb_vlu_load_sequencer;

  localparam int AW = 32;
  localparam int BB = 16;
  localparam int VW = 16;
  localparam int IW = 3;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_base = '0;
  logic [VW-1:0] req_vlb = '0;
  logic [IW-1:0] req_id = '0;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          rsp_fire = 1'b0;
  logic          busy;
  logic          done;
  logic [IW-1:0] done_id;

  always #5 clk = ~clk;

  vlu_load_sequencer #(
    .AddrWidth(AW), .BeatBytes(BB), .VlBWidth(VW), .IdWidth(IW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_base_i(req_base),
    .req_vlb_i(req_vlb),
    .req_id_i(req_id),
    .mem_req_valid_o(mem_valid),
    .mem_req_ready_i(mem_ready),
    .mem_req_addr_o(mem_addr),
    .rsp_fire_i(rsp_fire),
    .busy_o(busy),
    .done_o(done),
    .done_id_o(done_id)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [IW-1:0] id;
    int            nb;
  } instr_t;

  logic [AW-1:0] exp_addr_q[$];
  instr_t        exp_instr_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Memory / VLU model: every accepted beat becomes one operand the VLU may
  // later consume; consumes are only ever generated for delivered operands
  // unless force_rsp injects spurious ones.
  // -------------------------------------------------------------------------
  int ready_prob = 100;
  int rsp_prob   = 100;
  bit force_rsp  = 1'b0;
  int avail      = 0;
  bit nxt_rsp    = 1'b0;
  bit nxt_ready  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      avail = 0;
    end else begin
      if (mem_valid && mem_ready) avail++;
      if (rsp_fire && avail > 0) avail--;
    end
    nxt_rsp   = force_rsp || (rst_n && avail > 0 && int'($urandom_range(0, 99)) < rsp_prob);
    nxt_ready = int'($urandom_range(0, 99)) < ready_prob;
  end

  always @(posedge clk) begin
    #1;
    rsp_fire  = nxt_rsp;
    mem_ready = nxt_ready;
  end

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  int            m_out = 0;
  int            m_issued = 0;
  int            m_consumed = 0;
  int            m_nb = 0;
  bit            m_active = 1'b0;
  logic [IW-1:0] m_id = '0;
  int            beats_total = 0;
  int            dones_total = 0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  bit            mb_beat;
  bit            mb_rsp;
  bit            mb_exp_done;
  logic [AW-1:0] mb_exp_addr;
  instr_t        mb_instr;

  always @(negedge clk) begin
    if (!rst_n) begin
      // Reset drops the instruction in flight together with its credit.
      m_out      = 0;
      m_issued   = 0;
      m_consumed = 0;
      m_active   = 1'b0;
      prev_stall = 1'b0;
      exp_addr_q.delete();
      exp_instr_q.delete();
    end else begin
      mb_beat = mem_valid && mem_ready;
      mb_rsp  = rsp_fire && (m_out > 0);

      chk("req_ready", req_ready, !m_active);
      chk("busy", busy, m_active);

      if (m_active && m_nb > 0 && m_issued < m_nb)
        chk("mem_valid_issue", mem_valid, m_out < MO);
      else
        chk("mem_valid_quiet", mem_valid, 1'b0);

      if (prev_stall) begin
        chk("stall_valid_held", mem_valid, 1'b1);
        chk("stall_addr_held", mem_addr, prev_addr);
      end

      if (mb_beat) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          mb_exp_addr = exp_addr_q.pop_front();
          chk("beat_addr", mem_addr, mb_exp_addr);
        end
        m_issued++;
        beats_total++;
      end

      if (mb_rsp) m_consumed++;
      m_out = m_out + (mb_beat ? 1 : 0) - (mb_rsp ? 1 : 0);

      if (m_nb == 0) mb_exp_done = m_active;
      else           mb_exp_done = m_active && mb_rsp && (m_consumed == m_nb);

      if (done || mb_exp_done) begin
        chk("done", done, mb_exp_done);
        if (mb_exp_done) begin
          chk("done_id", done_id, m_id);
          $display("[%0t] load id=%0d beats=%0d complete", $time, m_id, m_nb);
          m_active = 1'b0;
          dones_total++;
        end
      end else begin
        chk("done_id_idle", done_id, '0);
      end

      if (req_valid && req_ready) begin
        if (exp_instr_q.size() == 0) begin
          chk("unexpected_accept", 1'b1, 1'b0);
        end else begin
          mb_instr   = exp_instr_q.pop_front();
          m_nb       = mb_instr.nb;
          m_id       = mb_instr.id;
          m_issued   = 0;
          m_consumed = 0;
          m_active   = 1'b1;
        end
      end

      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic send(input logic [AW-1:0] base, input int vlb, input logic [IW-1:0] id);
    int            nb;
    logic [AW-1:0] first;
    instr_t        t;
    bit            acc;
    int            n;
    nb    = (vlb + BB - 1) / BB;
    first = base - (base % BB);
    for (int i = 0; i < nb; i++) exp_addr_q.push_back(first + AW'(i * BB));
    t.id = id;
    t.nb = nb;
    exp_instr_q.push_back(t);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_base  = base;
    req_vlb   = VW'(vlb);
    req_id    = id;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((m_active || exp_instr_q.size() != 0) && n < maxc) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("finish_in_time", (m_active || exp_instr_q.size() != 0), 1'b0);
    chk("all_beats_issued", exp_addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_done_id", done_id, '0);
  endtask

  int b0;
  int d0;

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic 4-beat load.
    ready_prob = 100; rsp_prob = 100;
    d0 = dones_total;
    send(32'h0000_1000, 64, 3'd5);
    wait_idle(200);
    chk("basic_dones", dones_total - d0, 1);

    // Credit limit: only MaxOutstanding beats go out without consumes.
    rsp_prob = 0;
    b0 = beats_total;
    send(32'h0000_2000, 100, 3'd2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("held_beats", beats_total - b0, MO);
    chk("held_valid_low", mem_valid, 1'b0);
    rsp_prob = 100;
    wait_idle(200);
    chk("total_beats_vlb100", beats_total - b0, 7);

    // Zero-length load.
    b0 = beats_total; d0 = dones_total;
    send(32'h0000_3000, 0, 3'd7);
    wait_idle(20);
    chk("zero_beats", beats_total - b0, 0);
    chk("zero_dones", dones_total - d0, 1);

    // Alignment plus address wrap.
    send(32'hFFFF_FFF8, 32, 3'd1);
    wait_idle(200);

    // Memory stall with valid held high.
    ready_prob = 0;
    send(32'h0000_4008, 64, 3'd4);
    repeat (6) @(posedge clk);
    ready_prob = 100;
    wait_idle(200);

    // Spurious consumes while idle must not disturb the next load.
    force_rsp = 1'b1;
    repeat (3) @(posedge clk);
    force_rsp = 1'b0;
    repeat (2) @(posedge clk);
    send(32'h0000_5000, 48, 3'd6);
    wait_idle(200);

    // Reset in the middle of an issue phase drops the instruction.
    rsp_prob = 0;
    d0 = dones_total;
    send(32'h0000_6000, 160, 3'd3);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_prob = 100;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("no_done_after_reset", dones_total - d0, 0);
    send(32'h0000_7000, 80, 3'd0);
    wait_idle(200);

    // Randomised loads with random memory and VLU throttling.
    for (int k = 0; k < 40; k++) begin
      ready_prob = int'($urandom_range(20, 100));
      rsp_prob   = int'($urandom_range(20, 100));
      send($urandom, int'($urandom_range(0, 200)), IW'($urandom));
      wait_idle(3000);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
